// File: rtl/lsu_data_memory_if.sv
// Request/response bus between the LSU client (ALU/regfile side) and the data memory.
interface lsu_data_memory_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_data_memory.sv
// Byte-addressed RISC-V data memory: SB/SH/SW stores, LB/LH/LW/LBU/LHU loads,
// configurable read latency, error reporting and a zeroing sweep after reset.
module lsu_data_memory #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_data_memory_if.slave    bus,
  output logic                init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // First byte address past the array, one bit wider than the bus so it never wraps.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);
  // WAIT always holds at least one cycle so the response lines come straight off flops;
  // a load therefore preloads READ_LAT-1 extra cycles.
  localparam logic [2:0] LOAD_WAIT = 3'(READ_LAT - 1);

  logic [31:0]      mem_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [2:0]       wait_cnt_q, wait_cnt_d;
  logic             init_done_q, init_done_d;
  logic [31:0]      hold_rdata_q, hold_rdata_d;
  logic             hold_err_q, hold_err_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_off;
  logic             req_bad;
  logic [31:0]      rd_word;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_val;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign req_idx = bus.req_addr[IDX_W+1:2];
  assign req_off = bus.req_addr[1:0];
  assign rd_word = mem_q[req_idx];

  // Classify the presented request: range, alignment and funct3 legality.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    req_bad = 1'b0;
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT) req_bad = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && req_off[0]) req_bad = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && req_off != 2'b00) req_bad = 1'b1;
    if (bus.req_we) begin
      if (bus.req_funct3 > 3'b010) req_bad = 1'b1;
    end else begin
      if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11) req_bad = 1'b1;
    end
  end

  // Extract the addressed lane from the current word and extend it per funct3.
  always_comb begin
    lane_b   = rd_word[7:0];
    lane_h   = req_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'd0;
    case (req_off)
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      2'd3:    lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    case (bus.req_funct3)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = 32'd0;
    endcase
  end

  // Array write port: clear sweep during INIT, lane-masked store on a legal accept.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_be   = 4'b1111;
    wr_data = bus.req_wdata;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_q;
      wr_data = 32'd0;
    end else if (accept && bus.req_we && !req_bad) begin
      wr_en = 1'b1;
      case (bus.req_funct3[1:0])
        2'b00: begin
          wr_be   = 4'b0001 << req_off;
          wr_data = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          wr_be   = 4'b0011 << req_off;
          wr_data = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = bus.req_wdata;
        end
      endcase
    end
  end

  // Next-state logic for the sweep, request acceptance, latency count and response.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    wait_cnt_d   = wait_cnt_q;
    init_done_d  = init_done_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    case (state_q)
      ST_INIT: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_WAIT;
          hold_err_d   = req_bad;
          hold_rdata_d = (bus.req_we || req_bad) ? 32'd0 : load_val;
          wait_cnt_d   = (bus.req_we || req_bad) ? 3'd0 : LOAD_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = ST_RESP;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    resp_valid_d = (state_d == ST_RESP);
    resp_rdata_d = (state_d == ST_RESP) ? hold_rdata_q : 32'd0;
    resp_err_d   = (state_d == ST_RESP) && hold_err_q;
  end

  // Control and response registers; reset restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q      <= ST_INIT;
      clr_idx_q    <= '0;
      wait_cnt_q   <= 3'd0;
      init_done_q  <= 1'b0;
      hold_rdata_q <= 32'd0;
      hold_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      init_done_q  <= init_done_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the post-reset sweep zeroes it so it can map to RAM.
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-array model.
module tb_lsu_data_memory;

  localparam int DEPTH    = 256;
  localparam int READ_LAT = 3;
  localparam int BYTES    = 4 * DEPTH;

  logic clk;
  logic rst_n;
  logic init_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [BYTES];

  lsu_data_memory_if #(.ADDR_W(32)) bus ();

  lsu_data_memory #(
    .ADDR_W  (32),
    .DEPTH   (DEPTH),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (addr >= 32'(BYTES)) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    logic [31:0] b;
    logic [31:0] h;
    a = int'(addr);
    b = 32'(ref_mem[a]);
    case (f3)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1, 3'd5: begin
        h = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 32'd256;
        if (f3 == 3'd1 && h >= 32'd32768) return h | 32'hFFFF_0000;
        return h;
      end
      default: return 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 32'd256
                    + 32'(ref_mem[a+2]) * 32'd65536 + 32'(ref_mem[a+3]) * 32'd16777216;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    v = wd;
    for (int i = 0; i < n; i++) begin
      ref_mem[int'(addr) + i] = v[7:0];
      v = v >> 8;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Releases reset (caller holds rst_n low) with a junk store held on the bus,
  // and measures the sweep length.
  task automatic run_init(input string tag);
    int  cnt;
    logic ready_seen;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    ready_seen = 1'b0;
    while (!init_done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (!init_done && bus.req_ready) ready_seen = 1'b1;
    end
    bus.req_valid = 1'b0;
    check({tag, "_init_cycles"}, 32'(cnt), 32'(DEPTH));
    check({tag, "_ready_early"}, 32'(ready_seen), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    int n;
    int exp_lat;
    logic exp_err;
    logic [31:0] exp_data;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp_err  = model_err(we, f3, addr);
    exp_data = 32'd0;
    if (!exp_err) begin
      if (we) model_store(f3, addr, wd);
      else    exp_data = model_load(f3, addr);
    end
    exp_lat = (we || exp_err) ? 1 : READ_LAT;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, bus.resp_rdata, exp_data);
    check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {bus.resp_valid, bus.resp_err, bus.req_ready}, 32'b001);
    check({tag, "_rdata_idle"}, bus.resp_rdata, 32'd0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    clear_model();

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    run_init("init1");
    do_req(1'b0, 3'd2, 32'h3FC, 32'd0, "lw_top");
    do_req(1'b0, 3'd2, 32'h000, 32'd0, "lw_init_ignored");

    do_req(1'b1, 3'd2, 32'h10, 32'h1234_5678, "sw_10");
    do_req(1'b0, 3'd2, 32'h10, 32'd0, "lw_10");

    do_req(1'b1, 3'd0, 32'h21, 32'hFFFF_FF80, "sb_21");
    do_req(1'b0, 3'd0, 32'h21, 32'd0, "lb_21");
    do_req(1'b0, 3'd4, 32'h21, 32'd0, "lbu_21");
    do_req(1'b0, 3'd2, 32'h20, 32'd0, "lw_20");

    do_req(1'b1, 3'd2, 32'h30, 32'hAAAA_AAAA, "sw_30");
    do_req(1'b1, 3'd1, 32'h32, 32'h5555_BEEF, "sh_32");
    do_req(1'b0, 3'd2, 32'h30, 32'd0, "lw_30");
    do_req(1'b0, 3'd1, 32'h32, 32'd0, "lh_32");
    do_req(1'b0, 3'd5, 32'h32, 32'd0, "lhu_32");

    do_req(1'b0, 3'd2, 32'h02, 32'd0, "err_lw_mis");
    do_req(1'b1, 3'd1, 32'h01, 32'h0000_FFFF, "err_sh_mis");
    do_req(1'b0, 3'd2, 32'h00, 32'd0, "lw_after_err");
    do_req(1'b0, 3'd2, 32'h400, 32'd0, "err_lw_oor");
    do_req(1'b0, 3'd3, 32'h10, 32'd0, "err_ld_f3");
    do_req(1'b1, 3'd2, 32'h3FC, 32'hCAFE_F00D, "sw_top");
    do_req(1'b0, 3'd2, 32'h3FC, 32'd0, "lw_top2");

    // Reset while a load is waiting out its latency: no response, memory re-cleared.
    do_req(1'b1, 3'd2, 32'h40, 32'h0BAD_CAFE, "sw_40");
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h40;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_resp", {bus.resp_valid, bus.req_ready, init_done}, 32'd0);
    end
    run_init("init2");
    do_req(1'b0, 3'd2, 32'h40, 32'd0, "lw_40_cleared");

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      case ($urandom_range(0, 9))
        7:       addr = 32'h3F0 + 32'($urandom_range(0, 15));
        8:       addr = $urandom;
        9:       addr = 32'h400 + 32'($urandom_range(0, 15));
        default: addr = 32'($urandom_range(0, 15)) * 4
                        + (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      endcase
      do_req(we, f3, addr, $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
